// File: rtl/line_packer.sv
// ---------------------------------------------------------------------------
// line_packer
//
// Drains the record coupler's pair FIFO (show-ahead head + empty/deq) and
// packs LINE_PAIRS consecutive pairs into one wide line. The line is pushed
// into the memory-write FIFO (enq/full).
//
// A zero record marks the end of a stream. When it arrives, the partial line
// is flushed zero-padded and flagged o_last.
//
// Optional build macro: LINE_PACKER_RECCNT_EN
//   When defined, the block adds o_rec_cnt. This output counts the nonzero
//   records popped in the current stream and saturates at 2^32-1.
//
// Ports
//   i_clk      clock; all state changes on the rising edge
//   i_rst_n    asynchronous active-low reset
//   i_pair     upstream head {second, first}; first is in the low half
//   i_empty    upstream FIFO empty
//   o_deq      pop the upstream head this cycle
//   o_line     packed line; pair k sits at bits [(k+1)*2*P_WIDTH-1 : k*2*P_WIDTH]
//   o_last     o_line is the final line of its stream
//   o_enq      push o_line/o_last downstream this cycle
//   i_full     downstream FIFO full
//   o_err      sticky: end marker arrived with a nonzero upper half
//   o_rec_cnt  (LINE_PACKER_RECCNT_EN only) nonzero records in current stream
// ---------------------------------------------------------------------------
// state | meaning
// FILL  | popping pairs into slots 0..LINE_PAIRS-1
// EMIT  | line complete; waiting for downstream space, no pops
// ---------------------------------------------------------------------------
module line_packer #(
    parameter int P_WIDTH    = 128,
    parameter int LINE_PAIRS = 4
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic [2*P_WIDTH-1:0]               i_pair,
    input  logic                               i_empty,
    output logic                               o_deq,
    output logic [LINE_PAIRS*2*P_WIDTH-1:0]    o_line,
    output logic                               o_last,
    output logic                               o_enq,
    input  logic                               i_full,
    output logic                               o_err
`ifdef LINE_PACKER_RECCNT_EN
    ,
    output logic [31:0]                        o_rec_cnt
`endif
);

    localparam int PAIR_W  = 2 * P_WIDTH;
    localparam int L_WIDTH = LINE_PAIRS * PAIR_W;
    localparam int CW      = (LINE_PAIRS > 1) ? $clog2(LINE_PAIRS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(LINE_PAIRS - 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [L_WIDTH-1:0]   line_q, line_d;
    logic                 last_q, last_d;
    logic                 err_q, err_d;

    logic                 pop;
    logic                 push;
    logic [P_WIDTH-1:0]   rec_lo;
    logic [P_WIDTH-1:0]   rec_hi;
    logic                 lo_zero;
    logic                 hi_zero;

    assign rec_lo  = i_pair[P_WIDTH-1:0];
    assign rec_hi  = i_pair[PAIR_W-1:P_WIDTH];
    assign lo_zero = (rec_lo == '0);
    assign hi_zero = (rec_hi == '0);

    // Handshakes are gated with the reset input.
    // This keeps the block from popping or pushing while it is held in reset.
    assign pop  = (state_q == S_FILL) & ~i_empty & i_rst_n;
    assign push = (state_q == S_EMIT) & ~i_full & i_rst_n;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        last_d  = last_q;
        err_d   = err_q;
        o_deq   = 1'b0;
        o_enq   = 1'b0;

        case (state_q)
            S_FILL: begin
                o_deq = pop;
                if (pop) begin
                    if (lo_zero) begin
                        // End marker: the slot stays zero.
                        // This works because the line register is cleared on every emit.
                        // A nonzero upper half is a protocol violation, and that data is dropped.
                        if (!hi_zero) begin
                            err_d = 1'b1;
                        end
                        last_d  = 1'b1;
                        state_d = S_EMIT;
                    end else begin
                        line_d[int'(cnt_q)*PAIR_W +: PAIR_W] = i_pair;
                        if (hi_zero) begin
                            // Final record with the terminator in the same pair.
                            last_d  = 1'b1;
                            state_d = S_EMIT;
                        end else if (cnt_q == CNT_MAX) begin
                            state_d = S_EMIT;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
            end
            S_EMIT: begin
                o_enq = push;
                if (push) begin
                    line_d  = '0;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                    state_d = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_FILL;
            cnt_q   <= '0;
            line_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign o_line = line_q;
    assign o_last = last_q;
    assign o_err  = err_q;

`ifdef LINE_PACKER_RECCNT_EN
    logic [31:0] rec_cnt_q, rec_cnt_d;
    logic        new_stream_q, new_stream_d;
    logic [1:0]  pair_recs;
    logic [31:0] cnt_base;
    logic [32:0] cnt_sum;

    // Only records that are actually stored are counted.
    // A violating end marker therefore contributes nothing.
    always_comb begin
        pair_recs    = 2'd0;
        cnt_base     = '0;
        cnt_sum      = '0;
        rec_cnt_d    = rec_cnt_q;
        new_stream_d = new_stream_q;

        if (!lo_zero) begin
            pair_recs = hi_zero ? 2'd1 : 2'd2;
        end

        if (pop) begin
            // The first pop of a new stream restarts the count.
            // Until then, the previous stream's total remains visible.
            cnt_base     = new_stream_q ? 32'd0 : rec_cnt_q;
            cnt_sum      = {1'b0, cnt_base} + 33'(pair_recs);
            rec_cnt_d    = cnt_sum[32] ? '1 : cnt_sum[31:0];
            new_stream_d = 1'b0;
        end else if (push && last_q) begin
            new_stream_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rec_cnt_q    <= '0;
            new_stream_q <= 1'b1;
        end else begin
            rec_cnt_q    <= rec_cnt_d;
            new_stream_q <= new_stream_d;
        end
    end

    assign o_rec_cnt = rec_cnt_q;
`endif

endmodule
